// File: rtl/weather_pkg.sv
// -----------------------------------------------------------------------------
// weather_pkg
// Shared definitions for the weather classifier blocks: class codes, the
// humidity band boundaries that split the decision tree into ten bands, and
// the secondary humidity/temperature thresholds resolved inside each band.
// All values are unsigned fixed-point x100 (7785 = 77.85) and fit in 14 bits.
// -----------------------------------------------------------------------------
package weather_pkg;

    typedef enum logic [2:0] {
        CLS_CLEAR       = 3'd0,
        CLS_RAIN_OVC    = 3'd1,
        CLS_RAIN_PC     = 3'd2,
        CLS_PART_CLOUDY = 3'd3,
        CLS_OVERCAST    = 3'd4,  // reserved, the tree never produces it
        CLS_NONE        = 3'd7
    } wc_class_e;

    localparam logic [2:0] NONE = 3'd7;

    localparam int BAND_W    = 4;
    localparam int NUM_BANDS = 10;
    localparam int THR_W     = 14;

    // Upper (inclusive) humidity bound of bands 0..8; band 9 is everything above.
    localparam logic [THR_W-1:0] H_BAND [NUM_BANDS-1] = '{
        14'd3155, 14'd3270, 14'd4060, 14'd5125, 14'd7785,
        14'd8075, 14'd8515, 14'd8875, 14'd9215
    };

    // Secondary humidity splits used inside band 5.
    localparam logic [THR_W-1:0] H_B5_A = 14'd7855;
    localparam logic [THR_W-1:0] H_B5_B = 14'd7895;
    localparam logic [THR_W-1:0] H_B5_C = 14'd8025;
    localparam logic [THR_W-1:0] H_B5_D = 14'd7805;

    // Temperature splits per band.
    localparam logic [THR_W-1:0] T_B3   = 14'd2445;
    localparam logic [THR_W-1:0] T_B5_A = 14'd2645;
    localparam logic [THR_W-1:0] T_B5_B = 14'd2695;
    localparam logic [THR_W-1:0] T_B6   = 14'd2760;
    localparam logic [THR_W-1:0] T_B7   = 14'd2320;
    localparam logic [THR_W-1:0] T_B8   = 14'd2435;

endpackage

// File: rtl/wc_tree_eval.sv
// -----------------------------------------------------------------------------
// wc_tree_eval
// Combinational leaf resolution of the weather decision tree. The humidity band
// has already been computed upstream; this block applies the remaining
// temperature and fine humidity splits of that band.
// Ports:
//   band_i  - humidity band index 0..9
//   hum_i   - humidity x100
//   temp_i  - temperature x100
//   class_o - resulting class code (CLS_NONE for an impossible band)
// -----------------------------------------------------------------------------
module wc_tree_eval
    import weather_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [BAND_W-1:0] band_i,
    input  logic [DATA_W-1:0] hum_i,
    input  logic [DATA_W-1:0] temp_i,
    output logic [2:0]        class_o
);

    // Leaf selection per humidity band.
    always_comb begin
        class_o = CLS_NONE;
        case (band_i)
            4'd0: class_o = CLS_CLEAR;
            4'd1: class_o = CLS_PART_CLOUDY;
            4'd2: class_o = CLS_CLEAR;
            4'd3: begin
                if (temp_i <= DATA_W'(T_B3)) class_o = CLS_CLEAR;
                else                         class_o = CLS_PART_CLOUDY;
            end
            4'd4: class_o = CLS_PART_CLOUDY;
            4'd5: begin
                // Cool samples alternate between bands of humidity; warm ones
                // only split once at 78.05.
                if (temp_i <= DATA_W'(T_B5_A)) begin
                    if (hum_i <= DATA_W'(H_B5_A))      class_o = CLS_PART_CLOUDY;
                    else if (hum_i <= DATA_W'(H_B5_B)) class_o = CLS_RAIN_PC;
                    else if (hum_i <= DATA_W'(H_B5_C)) class_o = CLS_PART_CLOUDY;
                    else                               class_o = CLS_RAIN_PC;
                end else if (temp_i <= DATA_W'(T_B5_B)) begin
                    class_o = CLS_RAIN_PC;
                end else begin
                    if (hum_i <= DATA_W'(H_B5_D)) class_o = CLS_PART_CLOUDY;
                    else                          class_o = CLS_RAIN_PC;
                end
            end
            4'd6: begin
                if (temp_i <= DATA_W'(T_B6)) class_o = CLS_RAIN_PC;
                else                         class_o = CLS_PART_CLOUDY;
            end
            4'd7: begin
                if (temp_i <= DATA_W'(T_B7)) class_o = CLS_RAIN_OVC;
                else                         class_o = CLS_RAIN_PC;
            end
            4'd8: begin
                if (temp_i <= DATA_W'(T_B8)) class_o = CLS_RAIN_PC;
                else                         class_o = CLS_RAIN_OVC;
            end
            4'd9: class_o = CLS_RAIN_OVC;
            default: class_o = CLS_NONE;
        endcase
    end

endmodule

// File: rtl/weather_classifier_stream.sv
// -----------------------------------------------------------------------------
// weather_classifier_stream
// Streaming multi-channel weather classifier. Samples (channel, humidity, temp)
// enter over valid/ready; S1 registers the sample and its humidity band, S2
// resolves the tree leaf, shifts it into that channel's history and registers
// the majority-vote result. Output beats are held until out_ready.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   hist_clr        - one-cycle pulse emptying every channel history
//   in_valid/ready  - input handshake; in_ch >= NUM_CH is accepted and dropped
//   in_ch, in_humidity, in_temp - sample
//   out_valid/ready - output handshake
//   out_ch          - channel of the result
//   out_class_raw   - tree result of this sample
//   out_class       - majority-filtered class of the channel
//   out_stable      - history full and all entries equal
// -----------------------------------------------------------------------------
module weather_classifier_stream
    import weather_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_CH     = 4,
    parameter int HIST_DEPTH = 4,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hist_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_humidity,
    input  logic [DATA_W-1:0] in_temp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [2:0]        out_class_raw,
    output logic [2:0]        out_class,
    output logic              out_stable
);

    localparam int CNT_W = $clog2(HIST_DEPTH + 1);

    // Entry 0 is the newest class of the channel.
    typedef logic [HIST_DEPTH-1:0][2:0] hist_t;

    // Band = number of band boundaries strictly below h (boundaries ascend).
    function automatic logic [BAND_W-1:0] band_of(input logic [DATA_W-1:0] h);
        logic [BAND_W-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_BANDS - 1; i++) begin
            if (h > DATA_W'(H_BAND[i])) b = b + 4'd1;
        end
        return b;
    endfunction

    // Most frequent class among the first cnt entries; any tie for the top
    // count falls back to the newest raw class.
    function automatic logic [2:0] vote_of(input hist_t ent, input logic [CNT_W-1:0] cnt,
                                           input logic [2:0] raw);
        logic [CNT_W-1:0] tally [8];
        logic [CNT_W-1:0] best_n;
        logic [2:0]       best_c;
        logic             tie;
        for (int c = 0; c < 8; c++) begin
            tally[c] = '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                if ((CNT_W'(i) < cnt) && (ent[i] == 3'(c))) tally[c] = tally[c] + CNT_W'(1);
            end
        end
        best_n = '0;
        best_c = raw;
        tie    = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (tally[c] > best_n) begin
                best_n = tally[c];
                best_c = 3'(c);
                tie    = 1'b0;
            end else if ((tally[c] == best_n) && (best_n != '0)) begin
                tie = 1'b1;
            end
        end
        return tie ? raw : best_c;
    endfunction

    function automatic logic all_equal(input hist_t ent);
        logic eq;
        eq = 1'b1;
        for (int i = 1; i < HIST_DEPTH; i++) begin
            if (ent[i] != ent[0]) eq = 1'b0;
        end
        return eq;
    endfunction

    // Pipeline registers
    logic              s1_valid_q, s1_valid_d;
    logic [CH_W-1:0]   s1_ch_q, s1_ch_d;
    logic [DATA_W-1:0] s1_hum_q, s1_hum_d;
    logic [DATA_W-1:0] s1_temp_q, s1_temp_d;
    logic [BAND_W-1:0] s1_band_q, s1_band_d;
    logic              s2_valid_q, s2_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [2:0]        raw_q, raw_d;
    logic [2:0]        cls_q, cls_d;
    logic              stable_q, stable_d;

    // Per-channel history
    hist_t             hist_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];

    // Combinational helpers
    logic              s2_en_s, s1_en_s, fire_s, ch_ok_s, s2_load_s;
    logic [2:0]        raw_s;
    hist_t             ent_old_s, ent_new_s;
    logic [CNT_W-1:0]  cnt_old_s, cnt_new_s;

    wc_tree_eval #(.DATA_W(DATA_W)) u_tree (
        .band_i  (s1_band_q),
        .hum_i   (s1_hum_q),
        .temp_i  (s1_temp_q),
        .class_o (raw_s)
    );

    // Handshake and stage enables: a stage advances when its successor can take data.
    always_comb begin
        s2_en_s   = !s2_valid_q || out_ready;
        s1_en_s   = !s1_valid_q || s2_en_s;
        fire_s    = in_valid && s1_en_s && !rst;
        ch_ok_s   = int'(in_ch) < NUM_CH;
        s2_load_s = s2_en_s && s1_valid_q;
    end

    // History view of the S1 channel after this cycle's clear and shift.
    always_comb begin
        ent_old_s = hist_q[s1_ch_q];
        cnt_old_s = hist_clr ? '0 : cnt_q[s1_ch_q];
        ent_new_s = ent_old_s;
        ent_new_s[0] = raw_s;
        for (int i = 1; i < HIST_DEPTH; i++) begin
            ent_new_s[i] = ent_old_s[i-1];
        end
        if (cnt_old_s == CNT_W'(HIST_DEPTH)) cnt_new_s = cnt_old_s;
        else                                 cnt_new_s = cnt_old_s + CNT_W'(1);
    end

    // Next-state of both pipeline stages.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ch_d    = s1_ch_q;
        s1_hum_d   = s1_hum_q;
        s1_temp_d  = s1_temp_q;
        s1_band_d  = s1_band_q;
        s2_valid_d = s2_valid_q;
        out_ch_d   = out_ch_q;
        raw_d      = raw_q;
        cls_d      = cls_q;
        stable_d   = stable_q;

        if (s1_en_s) s1_valid_d = fire_s && ch_ok_s;
        else         s1_valid_d = s1_valid_q;

        if (fire_s && ch_ok_s) begin
            s1_ch_d   = in_ch;
            s1_hum_d  = in_humidity;
            s1_temp_d = in_temp;
            s1_band_d = band_of(in_humidity);
        end else begin
            s1_band_d = s1_band_q;
        end

        if (s2_en_s) s2_valid_d = s1_valid_q;
        else         s2_valid_d = s2_valid_q;

        if (s2_load_s) begin
            out_ch_d = s1_ch_q;
            raw_d    = raw_s;
            cls_d    = vote_of(ent_new_s, cnt_new_s, raw_s);
            stable_d = (cnt_new_s == CNT_W'(HIST_DEPTH)) && all_equal(ent_new_s);
        end else begin
            stable_d = stable_q;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_hum_q   <= '0;
            s1_temp_q  <= '0;
            s1_band_q  <= '0;
            s2_valid_q <= 1'b0;
            out_ch_q   <= '0;
            raw_q      <= NONE;
            cls_q      <= NONE;
            stable_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ch_q    <= s1_ch_d;
            s1_hum_q   <= s1_hum_d;
            s1_temp_q  <= s1_temp_d;
            s1_band_q  <= s1_band_d;
            s2_valid_q <= s2_valid_d;
            out_ch_q   <= out_ch_d;
            raw_q      <= raw_d;
            cls_q      <= cls_d;
            stable_q   <= stable_d;
        end
    end

    // Channel histories: a clear empties all counts, and the S2 write (which
    // already saw the clear) overrides its own channel afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hist_q[c] <= '{default: NONE};
                cnt_q[c]  <= '0;
            end
        end else begin
            if (hist_clr) begin
                for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
            end
            if (s2_load_s) begin
                hist_q[s1_ch_q] <= ent_new_s;
                cnt_q[s1_ch_q]  <= cnt_new_s;
            end
        end
    end

    assign in_ready      = s1_en_s && !rst;
    assign out_valid     = s2_valid_q;
    assign out_ch        = out_ch_q;
    assign out_class_raw = raw_q;
    assign out_class     = cls_q;
    assign out_stable    = stable_q;

endmodule

// File: tb/tb_weather_classifier_stream.sv
module tb_weather_classifier_stream;

    localparam int DATA_W     = 16;
    localparam int NUM_CH     = 5;   // leaves channel codes 5..7 to exercise the drop path
    localparam int HIST_DEPTH = 4;
    localparam int CH_W       = 3;

    logic              clk = 1'b0;
    logic              rst, hist_clr, in_valid, in_ready, out_valid, out_ready, out_stable;
    logic [CH_W-1:0]   in_ch, out_ch;
    logic [DATA_W-1:0] in_humidity, in_temp;
    logic [2:0]        out_class_raw, out_class;

    weather_classifier_stream #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .HIST_DEPTH(HIST_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .hist_clr(hist_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_humidity(in_humidity), .in_temp(in_temp),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_class_raw(out_class_raw), .out_class(out_class), .out_stable(out_stable)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Decision tree straight from the rule table.
    function automatic int ref_tree(input int h, input int t);
        if (h <= 3155) return 0;
        if (h <= 3270) return 3;
        if (h <= 4060) return 0;
        if (h <= 5125) return (t <= 2445) ? 0 : 3;
        if (h <= 7785) return 3;
        if (h <= 8075) begin
            if (t <= 2645) begin
                if (h <= 7855) return 3;
                if (h <= 7895) return 2;
                if (h <= 8025) return 3;
                return 2;
            end
            if (t <= 2695) return 2;
            return (h <= 7805) ? 3 : 2;
        end
        if (h <= 8515) return (t <= 2760) ? 2 : 3;
        if (h <= 8875) return (t <= 2320) ? 1 : 2;
        if (h <= 9215) return (t <= 2435) ? 2 : 1;
        return 1;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    typedef struct { int ch; int h; int t; } smp_t;
    smp_t acc_q[$];
    int   hist [NUM_CH][$];   // newest first
    bit   held     = 1'b0;
    bit   clr_pend = 1'b0;
    int   n_acc    = 0;

    always @(negedge clk) begin
        smp_t s;
        int   raw, cls, maxn, nmax, arg;
        int   tally [8];
        if (rst) begin
            acc_q.delete();
            for (int c = 0; c < NUM_CH; c++) hist[c].delete();
            held     = 1'b0;
            clr_pend = 1'b0;
        end else begin
            if (clr_pend) for (int c = 0; c < NUM_CH; c++) hist[c].delete();
            if (out_valid && !held) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_beat", out_valid, 0);
                end else begin
                    s   = acc_q.pop_front();
                    raw = ref_tree(s.h, s.t);
                    hist[s.ch].push_front(raw);
                    if (hist[s.ch].size() > HIST_DEPTH) void'(hist[s.ch].pop_back());
                    for (int k = 0; k < 8; k++) tally[k] = 0;
                    foreach (hist[s.ch][i]) tally[hist[s.ch][i]]++;
                    maxn = 0; nmax = 0; arg = 0;
                    for (int k = 0; k < 8; k++) if (tally[k] > maxn) begin maxn = tally[k]; arg = k; end
                    for (int k = 0; k < 8; k++) if (tally[k] == maxn) nmax++;
                    cls = (nmax == 1) ? arg : raw;
                    check("out_ch", out_ch, s.ch);
                    check("out_class_raw", out_class_raw, raw);
                    check("out_class", out_class, cls);
                    check("out_stable", out_stable, (tally[raw] == HIST_DEPTH) ? 1 : 0);
                end
            end
            held     = out_valid && !out_ready;
            clr_pend = hist_clr;
            if (in_valid && in_ready) begin
                n_acc++;
                if (int'(in_ch) < NUM_CH) acc_q.push_back('{int'(in_ch), int'(in_humidity), int'(in_temp)});
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int ch, input int h, input int t);
        in_ch = CH_W'(ch); in_humidity = DATA_W'(h); in_temp = DATA_W'(t); in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (in_ready) break;
            if (k == 49) check("send_timeout", in_ready, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic int pick_h();
        int thr [13] = '{3155, 3270, 4060, 5125, 7785, 8075, 8515, 8875, 9215, 7855, 7895, 8025, 7805};
        if ($urandom_range(0, 1) == 0) return thr[$urandom_range(0, 12)] + $urandom_range(0, 2) - 1;
        return $urandom_range(0, 10000);
    endfunction

    function automatic int pick_t();
        int thr [6] = '{2445, 2645, 2695, 2760, 2320, 2435};
        if ($urandom_range(0, 1) == 0) return thr[$urandom_range(0, 5)] + $urandom_range(0, 2) - 1;
        return $urandom_range(1800, 3200);
    endfunction

    initial begin
        int  acc0;
        bit  take;
        rst = 1'b1; hist_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ch = '0; in_humidity = '0; in_temp = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_class", out_class, 7);
        check("rst_out_class_raw", out_class_raw, 7);
        check("rst_out_stable", out_stable, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #1; rst = 1'b0;

        // T1: latency of a single sample
        @(posedge clk); #1;
        in_ch = 3'd0; in_humidity = 16'd3000; in_temp = 16'd2000; in_valid = 1'b1;
        @(negedge clk); #1; check("t1_in_ready", in_ready, 1);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); #1; check("t1_lat_cycle1", out_valid, 0);
        @(negedge clk); #1; check("t1_lat_cycle2", out_valid, 1);
        @(posedge clk); #1; idle(2);

        // T2: ch1 fills with class 1, then ch0 continues its own history
        for (int i = 0; i < 4; i++) send(1, 9500, 2000);
        send(0, 3000, 2000);
        idle(4);

        // T3: majority keeps class 2 while the newest raw is 1
        for (int i = 0; i < 3; i++) send(2, 8600, 2500);
        send(2, 9000, 2300);
        send(2, 9000, 2500);
        idle(4);

        // T4: back-pressure, two accepts then in_ready low, release in order
        out_ready = 1'b0;
        acc0 = n_acc;
        in_ch = 3'd4; in_humidity = 16'd3000; in_temp = 16'd2000; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1; take = in_ready;
            @(posedge clk); #1;
            if (take) in_humidity = (in_humidity == 16'd3000) ? 16'd3200 : 16'd9500;
        end
        @(negedge clk); #1;
        check("t4_accepts", n_acc - acc0, 2);
        check("t4_in_ready_low", in_ready, 0);
        @(posedge clk); #1; out_ready = 1'b1;
        for (int k = 0; k < 20 && in_valid; k++) begin
            @(negedge clk); #1; take = in_ready;
            @(posedge clk); #1;
            if (take) in_valid = 1'b0;
        end
        idle(4);

        // T5: clear coincident with the S2 load of ch3
        for (int i = 0; i < 3; i++) send(3, 3000, 2000);
        idle(3);
        send(3, 7000, 2000);
        hist_clr = 1'b1;
        @(posedge clk); #1; hist_clr = 1'b0;
        for (int i = 0; i < 4; i++) send(3, 3000, 2000);
        idle(4);

        // T6: out-of-range channels produce nothing
        send(5, 9500, 2000);
        send(7, 3000, 2000);
        idle(5);
        @(negedge clk); #1; check("t6_drop_no_beat", out_valid, 0);
        @(posedge clk); #1;

        // T6: reset with samples in flight
        out_ready = 1'b0;
        send(0, 9500, 2000);
        send(1, 8600, 2500);
        rst = 1'b1;
        @(negedge clk); #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_class", out_class, 7);
        check("t6_rst_in_ready", in_ready, 0);
        @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
        idle(5);
        @(negedge clk); #1; check("t6_no_beat_after_rst", out_valid, 0);
        @(posedge clk); #1;

        // Randomized traffic with back-pressure and occasional clears
        for (int i = 0; i < 800; i++) begin
            @(negedge clk); #1; take = in_valid && in_ready;
            @(posedge clk); #1;
            if (take || !in_valid) begin
                in_valid    = ($urandom_range(0, 3) != 0);
                in_ch       = CH_W'($urandom_range(0, 7));
                in_humidity = DATA_W'(pick_h());
                in_temp     = DATA_W'(pick_t());
            end
            out_ready = ($urandom_range(0, 3) != 0);
            hist_clr  = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk); #1; take = in_valid && in_ready;
        @(posedge clk); #1;
        if (!take) begin
            for (int k = 0; k < 20 && in_valid; k++) begin
                out_ready = 1'b1; hist_clr = 1'b0;
                @(negedge clk); #1; take = in_ready;
                @(posedge clk); #1;
                if (take) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1; hist_clr = 1'b0;
        for (int k = 0; k < 50 && acc_q.size() != 0; k++) @(negedge clk);
        #1;
        check("drain_pending", acc_q.size(), 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
